ex_cdb_stage: RTL
=================

# ex_cdb_stage

Execute stage directly downstream of dispatch/issue. Accepts one issued instruction per cycle (operands already read, ROB tag attached), executes it on a single-cycle ALU or a fixed-latency pipelined multiplier, and drives the single common data bus (CDB) that the RS, ROB and map table snoop. It owns CDB arbitration and applies issue back-pressure when completed ALU results cannot be broadcast.

## Interface
- XLEN, 32, operand/result width
- TAG_W, 5, ROB tag width
- MULT_STAGES, 4, multiplier latency in cycles (≥2)

- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- squash  in  1  synchronous flush (branch mispredict)
- issue_valid  in  1  issued instruction present
- issue_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SLT, 111 MUL
- issue_rs1  in  XLEN  operand A
- issue_rs2  in  XLEN  operand B
- issue_tag  in  TAG_W  destination ROB tag
- issue_ready  out  1  stage can accept an instruction this cycle
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  TAG_W  broadcast ROB tag
- cdb_value  out  XLEN  broadcast result

## Operation
- Accept = issue_valid & issue_ready & ~squash, sampled on rising clock edge.
- ALU ops: result computed in accept cycle, pushed into 2-entry ALU result FIFO (tag+value). SUB = A−B mod 2^XLEN; SLL shifts A by B[$clog2(XLEN)-1:0]; SLT = signed A<B ? 1 : 0.
- MUL: enters MULT_STAGES-deep valid/tag/data pipeline; result = low XLEN bits of A×B. Pipeline never stalls; internal partitioning is free provided latency is exact.
- CDB arbitration (combinational from registers only): multiplier last stage wins; else ALU FIFO head; else cdb_valid=0. Loser is held in FIFO.
- FIFO pops when its head drives the CDB. Push+pop same cycle: count unchanged.
- issue_ready = (ALU FIFO count < 2); depends on registered state only, never on issue_valid. Applies to MUL as well, so a full FIFO stops new MUL entry and the multiplier drains within MULT_STAGES cycles — ALU starvation is bounded.
- When cdb_valid=0, cdb_tag and cdb_value are 0.
- squash: at the edge, clear FIFO count and every multiplier valid bit; instruction presented in the squash cycle is dropped. No broadcast in the cycle after squash.

## Timing
- Reset (reset=0, asynchronous): FIFO empty, all multiplier valids 0; issue_ready=1, cdb_valid=0, cdb_tag=0, cdb_value=0 while asserted and until next accept produces a result.
- ALU latency: accepted at edge ending cycle t → on CDB in cycle t+1 if no multiplier completion that cycle.
- MUL latency: accepted at edge ending cycle t → on CDB in cycle t+MULT_STAGES, guaranteed.
- Throughput: one CDB broadcast per cycle max; one accept per cycle max.
- issue_ready drops the cycle after FIFO reaches 2; rises the cycle after a pop.
- Reset released mid-stream: pipeline contents are lost; no spurious broadcast.

## Test plan
- Reset then ADD 5+7 tag 3 at cycle 0 → cycle 1: cdb_valid=1, tag 3, value 12; cycle 2: cdb_valid=0.
- MUL 0xFFFF_FFFF×2 tag 1 at cycle 0, MULT_STAGES=4 → cycle 4: tag 1, value 0xFFFF_FFFE.
- MUL tag 1 at cycle 0, ADD tag 2 at cycle 3, XOR tag 4 at cycle 4 → cycle 4 MUL wins (tag 1); ADD tag 2 in cycle 5, XOR tag 4 in cycle 6; issue_ready stays 1.
- Back-to-back MUL tags 1..4 in cycles 0..3 then ALU ops each cycle → FIFO fills, issue_ready=0 by cycle 6; MUL tags 1..4 broadcast cycles 4..7; ALU results follow in issue order, no loss or duplication.
- Fill pipeline with 2 MUL + 2 ALU, assert squash one cycle → next cycle cdb_valid=0, issue_ready=1, no squashed tag ever broadcast.
- SLT −1 vs 1 → value 1; SLL 1 by 0x21 → value 2; SUB 0−1 → 0xFFFF_FFFF.

Source files
------------

// File: rtl/ex_cdb_stage.sv
// Execute stage: single-cycle ALU feeding a 2-entry result FIFO plus a fixed-latency
// multiplier pipeline, both arbitrated onto the one common data bus.
module ex_cdb_stage #(
    parameter int XLEN        = 32,
    parameter int TAG_W       = 5,
    parameter int MULT_STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    input  logic             issue_valid,
    input  logic [2:0]       issue_op,
    input  logic [XLEN-1:0]  issue_rs1,
    input  logic [XLEN-1:0]  issue_rs2,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             issue_ready,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_value
);

    localparam int SHAMT_W = $clog2(XLEN);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SLT = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    op_e             op;
    logic            accept;
    logic            alu_push;
    logic            mul_push;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] mul_low;

    logic [MULT_STAGES-1:0] mul_valid;
    logic [TAG_W-1:0]       mul_tag  [MULT_STAGES];
    logic [XLEN-1:0]        mul_data [MULT_STAGES];
    logic                   mul_done;

    logic [TAG_W-1:0] fifo_tag  [2];
    logic [XLEN-1:0]  fifo_data [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_count;
    logic             fifo_pop;

    assign op       = op_e'(issue_op);
    assign accept   = issue_valid & issue_ready & ~squash;
    assign mul_push = accept & (op == OP_MUL);
    assign alu_push = accept & (op != OP_MUL);
    assign mul_low  = issue_rs1 * issue_rs2;

    always_comb begin
        alu_result = '0;
        case (op)
            OP_ADD:  alu_result = issue_rs1 + issue_rs2;
            OP_SUB:  alu_result = issue_rs1 - issue_rs2;
            OP_AND:  alu_result = issue_rs1 & issue_rs2;
            OP_OR:   alu_result = issue_rs1 | issue_rs2;
            OP_XOR:  alu_result = issue_rs1 ^ issue_rs2;
            OP_SLL:  alu_result = issue_rs1 << issue_rs2[SHAMT_W-1:0];
            OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(issue_rs1) < $signed(issue_rs2))};
            default: alu_result = '0;
        endcase
    end

    // Product is formed on entry; later stages only delay it so latency stays exact.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mul_valid <= '0;
            for (int i = 0; i < MULT_STAGES; i++) begin
                mul_tag[i]  <= '0;
                mul_data[i] <= '0;
            end
        end else begin
            if (squash)
                mul_valid <= '0;
            else
                mul_valid <= {mul_valid[MULT_STAGES-2:0], mul_push};
            mul_tag[0]  <= issue_tag;
            mul_data[0] <= mul_low;
            for (int i = 1; i < MULT_STAGES; i++) begin
                mul_tag[i]  <= mul_tag[i-1];
                mul_data[i] <= mul_data[i-1];
            end
        end
    end

    assign mul_done    = mul_valid[MULT_STAGES-1];
    assign fifo_pop    = (fifo_count != 2'd0) & ~mul_done;
    assign issue_ready = (fifo_count < 2'd2);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_tag[i]  <= '0;
                fifo_data[i] <= '0;
            end
        end else if (squash) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (alu_push) begin
                fifo_tag[wr_ptr]  <= issue_tag;
                fifo_data[wr_ptr] <= alu_result;
                wr_ptr            <= ~wr_ptr;
            end
            if (fifo_pop)
                rd_ptr <= ~rd_ptr;
            case ({alu_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Multiplier completion has priority; a blocked ALU result simply waits in the FIFO.
    always_comb begin
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        cdb_value = '0;
        if (mul_done) begin
            cdb_valid = 1'b1;
            cdb_tag   = mul_tag[MULT_STAGES-1];
            cdb_value = mul_data[MULT_STAGES-1];
        end else if (fifo_count != 2'd0) begin
            cdb_valid = 1'b1;
            cdb_tag   = fifo_tag[rd_ptr];
            cdb_value = fifo_data[rd_ptr];
        end
    end

endmodule
